trng_req_arbiter: RTL and testbench



---
 rtl/trng_req_arbiter_if.sv | 26 ++
 rtl/trng_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_trng_req_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_req_arbiter_if.sv
// trng_req_arbiter_if: consumer-side word bus of the TRNG arbiter.
// req_i level requests, gnt_o one-hot grant, data_o word, level_o fill.
interface trng_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4
);
  logic [NUM_REQ-1:0]     req_i;
  logic [NUM_REQ-1:0]     gnt_o;
  logic [DATA_W-1:0]      data_o;
  logic [$clog2(DEPTH):0] level_o;

  modport master (
    output req_i,
    input  gnt_o,
    input  data_o,
    input  level_o
  );

  modport slave (
    input  req_i,
    output gnt_o,
    output data_o,
    output level_o
  );
endinterface

// File: rtl/trng_req_arbiter.sv
// trng_req_arbiter: sequences the TRNG (enable/ready/ack), buffers words
// in a hold register + FIFO, shares them round-robin, latches failures.
// Ports: clk_i, rst_i (sync, active-high), start_i, bus (req/gnt/data/
// level), trng_enable_o, trng_ready_i, trng_data_i, trng_ack_o,
// trng_dead_i, err_o (sticky), busy_o (START or RUN).
module trng_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  trng_req_arbiter_if.slave bus,
  output logic              trng_enable_o,
  input  logic              trng_ready_i,
  input  logic [DATA_W-1:0] trng_data_i,
  output logic              trng_ack_o,
  input  logic              trng_dead_i,
  output logic              err_o,
  output logic              busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FAILED
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic              hold_v_q;
  logic              ack_q;
  logic [PW-1:0]     rr_q;
  logic [WW-1:0]     wd_q;

  logic          run, full, pop, push, load;
  logic          proto_err, wd_run, wd_hit;
  logic          found;
  logic [PW-1:0] sel, idx;

  // dead overrides every other event of the cycle
  assign run  = (state_q == S_RUN) && !trng_dead_i;
  assign full = (cnt_q == FULL);

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(rr_q) + k) % NUM_REQ);
      if (!found && bus.req_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign pop  = run && (cnt_q != '0) && found;
  // room is judged after this cycle's pop
  assign push = run && hold_v_q && (!full || pop);
  assign load = run && trng_ready_i && !hold_v_q;

  assign proto_err = (state_q == S_RUN) && trng_ready_i && hold_v_q;
  assign wd_run    = (state_q == S_RUN) && !full && !hold_v_q
                     && !trng_ready_i;
  assign wd_hit    = wd_run && (wd_q >= WW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i) state_d = S_START;
      S_START:  state_d = trng_dead_i ? S_FAILED : S_RUN;
      S_RUN:    if (trng_dead_i || proto_err || wd_hit)
                  state_d = S_FAILED;
      S_FAILED: state_d = S_FAILED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt_o = '0;
    if (pop) bus.gnt_o[sel] = 1'b1;
  end

  assign bus.data_o  = pop ? mem[rd_q] : '0;
  assign bus.level_o = cnt_q;

  assign trng_enable_o = (state_q == S_START) && !trng_dead_i;
  assign trng_ack_o    = ack_q && run;
  assign err_o         = (state_q == S_FAILED);
  assign busy_o        = (state_q == S_START) || (state_q == S_RUN);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= hold_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      ack_q    <= 1'b0;
      rr_q     <= '0;
      wd_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_FAILED) begin
        wr_q     <= '0;
        rd_q     <= '0;
        cnt_q    <= '0;
        hold_v_q <= 1'b0;
        ack_q    <= 1'b0;
        wd_q     <= '0;
      end else begin
        ack_q <= push;
        if (pop) begin
          rd_q <= rd_q + 1'b1;
          rr_q <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
        end
        if (push) wr_q <= wr_q + 1'b1;
        if (push && !pop) cnt_q <= cnt_q + 1'b1;
        else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        if (push) hold_v_q <= 1'b0;
        if (load) begin
          hold_v_q <= 1'b1;
          hold_q   <= trng_data_i;
        end
        if (state_q != S_RUN || trng_ready_i || full) wd_q <= '0;
        else if (!hold_v_q && wd_q != WW'(TIMEOUT))
          wd_q <= wd_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_trng_req_arbiter.sv
// tb_trng_req_arbiter: random + directed stimulus against a queue-based
// model of the arbiter, plus literal expectations for key scenarios.
module tb_trng_req_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int DP = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst, start, ready, dead;
  logic [DW-1:0] tdata;
  logic          en, ack, err, busy;

  trng_req_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(DP)) bus ();

  trng_req_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .DEPTH(DP), .TIMEOUT(TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .bus          (bus),
    .trng_enable_o(en),
    .trng_ready_i (ready),
    .trng_data_i  (tdata),
    .trng_ack_o   (ack),
    .trng_dead_i  (dead),
    .err_o        (err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // model: 0 IDLE, 1 START, 2 RUN, 3 FAILED
  int              ms = 0;
  logic [DW-1:0]   q[$];
  bit              hv = 0;
  logic [DW-1:0]   hw = '0;
  bit              ap = 0;
  int              wd = 0;
  int              rr = 0;
  bit              running, hv0;
  int              gi, sz0;
  logic [N-1:0]    eg;
  logic [DW-1:0]   ed;

  task automatic m_fail();
    ms = 3; q.delete(); hv = 0; ap = 0; wd = 0;
  endtask

  always @(negedge clk) if (chk_en) begin
    running = (ms == 2) && !dead;
    gi = -1;
    if (running && q.size() > 0)
      for (int k = 0; k < N; k++)
        if (gi < 0 && bus.req_i[(rr + k) % N]) gi = (rr + k) % N;
    eg = '0;
    ed = '0;
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ed = q[0];
    end
    chk("gnt", 64'(bus.gnt_o), 64'(eg));
    chk("data", 64'(bus.data_o), 64'(ed));
    chk("level", 64'(bus.level_o), 64'(q.size()));
    chk("enable", 64'(en), 64'(ms == 1 && !dead));
    chk("ack", 64'(ack), 64'(ap && running));
    chk("err", 64'(err), 64'(ms == 3));
    chk("busy", 64'(busy), 64'(ms == 1 || ms == 2));
    if (rst) begin
      ms = 0; q.delete(); hv = 0; ap = 0; wd = 0; rr = 0;
    end else begin
      case (ms)
        0: if (start) ms = 1;
        1: if (dead) m_fail(); else ms = 2;
        2: if (dead) m_fail();
           else begin
             hv0 = hv;
             sz0 = q.size();
             ap = 0;
             if (gi >= 0) begin
               void'(q.pop_front());
               rr = (gi + 1) % N;
             end
             if (hv && q.size() < DP) begin
               q.push_back(hw); hv = 0; ap = 1;
             end
             if (ready && !hv0) begin
               hv = 1; hw = tdata;
             end
             if (ready || sz0 == DP) wd = 0;
             else if (!hv0) wd++;
             if ((ready && hv0) || wd >= TO) m_fail();
           end
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  // ends in the cycle where the ack is due
  task automatic send(input logic [DW-1:0] w_in);
    ready = 1'b1; tdata = w_in; tick(); ready = 1'b0; tick();
  endtask

  logic [DW-1:0] w [5];
  int gap, waiting, len, dead_at;

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; dead = 1'b0;
    tdata = '0; bus.req_i = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_gnt", 64'(bus.gnt_o), 64'(0));
    chk("rst_level", 64'(bus.level_o), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_en", 64'(en), 64'(0));

    start = 1'b1; tick(); start = 1'b0; #1;
    chk("start_en", 64'(en), 64'(1));
    chk("start_busy", 64'(busy), 64'(1));
    tick(); #1;
    chk("start_en_off", 64'(en), 64'(0));
    send(32'hDEADBEEF); #1;
    chk("first_ack", 64'(ack), 64'(1));
    chk("first_level", 64'(bus.level_o), 64'(1));
    tick(); #1;
    chk("first_ack_off", 64'(ack), 64'(0));

    do_reset(); start_run();
    bus.req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w[k] = $urandom;
      send(w[k]); #1;
      chk("rr_gnt", 64'(bus.gnt_o), 64'(4'b0001 << (k % 4)));
      chk("rr_data", 64'(bus.data_o), 64'(w[k]));
      tick();
    end
    bus.req_i = '0;

    do_reset(); start_run();
    for (int k = 0; k < 4; k++) begin
      w[k] = $urandom;
      send(w[k]); tick();
    end
    #1 chk("full_level", 64'(bus.level_o), 64'(4));
    w[4] = $urandom;
    ready = 1'b1; tdata = w[4]; tick(); ready = 1'b0; #1;
    chk("full_noack1", 64'(ack), 64'(0));
    tick(); #1;
    chk("full_noack2", 64'(ack), 64'(0));
    tick();
    bus.req_i = 4'b0100; #1;
    chk("full_gnt", 64'(bus.gnt_o), 64'(4'b0100));
    chk("full_data", 64'(bus.data_o), 64'(w[0]));
    tick();
    bus.req_i = '0; #1;
    chk("full_ack", 64'(ack), 64'(1));
    chk("full_level4", 64'(bus.level_o), 64'(4));

    do_reset(); start_run();
    w[0] = $urandom; w[1] = $urandom;
    send(w[0]); tick();
    ready = 1'b1; tdata = w[1]; tick(); ready = 1'b0;
    bus.req_i = 4'b0001; #1;
    chk("pp1_gnt", 64'(bus.gnt_o), 64'(4'b0001));
    chk("pp1_data", 64'(bus.data_o), 64'(w[0]));
    tick();
    bus.req_i = '0; #1;
    chk("pp1_level", 64'(bus.level_o), 64'(1));
    chk("pp1_ack", 64'(ack), 64'(1));
    send($urandom); tick();
    send($urandom); tick();
    #1 chk("dead_level3", 64'(bus.level_o), 64'(3));
    bus.req_i = 4'b0001; dead = 1'b1; #1;
    chk("dead_nognt", 64'(bus.gnt_o), 64'(0));
    tick();
    dead = 1'b0; #1;
    chk("dead_err", 64'(err), 64'(1));
    chk("dead_level", 64'(bus.level_o), 64'(0));
    start = 1'b1; tick(); tick(); #1;
    chk("fail_err", 64'(err), 64'(1));
    chk("fail_busy", 64'(busy), 64'(0));
    chk("fail_gnt", 64'(bus.gnt_o), 64'(0));
    start = 1'b0; bus.req_i = '0;

    do_reset(); start_run();
    repeat (19) tick();
    #1 chk("wd_before", 64'(err), 64'(0));
    tick(); #1;
    chk("wd_hit", 64'(err), 64'(1));

    do_reset(); start_run();
    bus.req_i = 4'b1111;
    repeat (12) begin
      ready = 1'b1; tdata = $urandom; tick(); ready = 1'b0;
      repeat (9) tick();
    end
    #1 chk("wd_fed_err", 64'(err), 64'(0));
    chk("wd_fed_busy", 64'(busy), 64'(1));
    bus.req_i = '0;

    do_reset(); start_run();
    send($urandom); tick();
    send($urandom); tick();
    #1 chk("rst_mid_level", 64'(bus.level_o), 64'(2));
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("rst_mid_level0", 64'(bus.level_o), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_ack", 64'(ack), 64'(0));

    do_reset(); start_run();
    ready = 1'b1; tdata = $urandom; tick(); tick(); ready = 1'b0; #1;
    chk("proto_err", 64'(err), 64'(1));

    for (int e = 0; e < 25; e++) begin
      do_reset(); start_run();
      gap = $urandom_range(0, 4);
      waiting = 0;
      len = $urandom_range(60, 200);
      dead_at = ($urandom_range(0, 2) == 0) ? $urandom_range(10, len) : -1;
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0)
          bus.req_i = N'($urandom) & N'($urandom);
        ready = 1'b0;
        if (waiting == 0) begin
          if (gap == 0) begin
            ready = 1'b1; tdata = $urandom; waiting = 1;
          end else gap--;
        end
        dead = (c == dead_at);
        #1;
        if (waiting != 0 && ack) begin
          waiting = 0;
          gap = $urandom_range(0, 10);
        end
        tick();
      end
      ready = 1'b0; dead = 1'b0; bus.req_i = '0;
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
